cos_feeder: RTL and testbench

Request sequencer placed directly upstream of the Maclaurin cosine core. It accepts angles over a valid/ready stream, buffers them in a small FIFO, and issues each one to the core with a single-cycle `start` pulse. It waits for `done`, captures the 18-bit result, and presents it downstream with valid/ready and a timeout error flag. The block serialises back-to-back requests so the core never sees a `start` while busy.

---
 rtl/cos_feeder.sv | 164 ++++++++++++++++
 tb/tb_cos_feeder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cos_feeder.sv
// Request sequencer for the Maclaurin cosine core: buffers angles in a FIFO,
// issues them one at a time with a start pulse and returns results or a timeout error.
module cos_feeder #(
    parameter int DEPTH   = 4,
    parameter int XW      = 16,
    parameter int RW      = 18,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [XW-1:0]            inX,
    output logic                     coreStart,
    output logic [XW-1:0]            coreX,
    input  logic [RW-1:0]            coreR,
    input  logic                     coreDone,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [RW-1:0]            outR,
    output logic [XW-1:0]            outX,
    output logic                     outErr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [7:0]    TMO_C  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [XW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [7:0]      tmo_cnt_r;
    logic            push_s;
    logic            pop_s;
    logic            done_hit_s;
    logic            tmo_hit_s;

    assign inReady = !rst && (count != FULL_C);
    assign push_s  = inValid && inReady;

    // Next-state decode; a pop happens only on the way into ISSUE.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        done_hit_s  = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count != '0) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A zero counter marks the guard cycle, where a stale done is masked.
                if ((tmo_cnt_r != 8'd0) && coreDone) begin
                    done_hit_s  = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else if (tmo_cnt_r == TMO_C) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (outReady) begin
                    if (count != '0) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, core request and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            coreStart <= 1'b0;
            coreX     <= '0;
            tmo_cnt_r <= 8'd0;
            outValid  <= 1'b0;
            outR      <= '0;
            outX      <= '0;
            outErr    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            coreStart <= pop_s;
            if (pop_s) begin
                coreX <= mem_r[rd_ptr_r];
            end
            if (state_r == ST_ISSUE) begin
                tmo_cnt_r <= 8'd0;
            end else if ((state_r == ST_WAIT) && !done_hit_s && !tmo_hit_s && (tmo_cnt_r != 8'hFF)) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end
            if (done_hit_s) begin
                outValid <= 1'b1;
                outR     <= coreR;
                outX     <= coreX;
                outErr   <= 1'b0;
            end else if (tmo_hit_s) begin
                outValid <= 1'b1;
                outR     <= '0;
                outX     <= coreX;
                outErr   <= 1'b1;
            end else if ((state_r == ST_HOLD) && outReady) begin
                outValid <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= inX;
        end
    end
endmodule

// File: tb/tb_cos_feeder.sv
// Self-checking bench for cos_feeder: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the sequencer.
module tb_cos_feeder;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst, inValid, inReady, coreStart, coreDone, outValid, outReady, outErr;
    logic [15:0] inX, coreX, outX;
    logic [17:0] coreR, outR;
    logic [2:0]  count;

    cos_feeder #(.DEPTH(DEPTH), .XW(16), .RW(18), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inX(inX),
        .coreStart(coreStart), .coreX(coreX), .coreR(coreR), .coreDone(coreDone),
        .outValid(outValid), .outReady(outReady), .outR(outR), .outX(outX),
        .outErr(outErr), .count(count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] rfun(input logic [15:0] x);
        return {x[7:0], x[15:6]} ^ 18'h2A5A5;
    endfunction

    // Core model configuration: 0 random, 1 fixed latency, 2 never done, 3 stale done
    int          cm_mode = 1;
    int          fix_lat = 20;
    logic        fix_en  = 1'b0;
    logic [17:0] fix_r   = 18'h0;
    int          cm_lat  = 0;

    initial begin : core_model
        int          pend, st, endc, m, r, lat;
        logic        stale, in_win;
        logic [15:0] cx;
        pend = 0; st = 0; endc = 0; lat = 0; stale = 1'b0; cx = 16'h0;
        coreDone = 1'b0;
        coreR    = 18'h0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                pend = 0; stale = 1'b0; coreDone = 1'b0;
            end else begin
                if (coreStart) begin
                    m = cm_mode;
                    if (m == 0) begin
                        r = $urandom_range(0, 19);
                        m = (r == 0) ? 2 : ((r == 1) ? 3 : 1);
                        lat = $urandom_range(2, 30);
                    end else begin
                        lat = fix_lat;
                    end
                    if (m == 2) lat = 0;
                    if (m == 3) lat = 6;
                    pend = 1; st = cyc; cx = coreX; stale = (m == 3);
                    endc = (lat == 0) ? st + TIMEOUT + 2 : st + lat;
                    cm_lat = lat;
                end
                in_win   = (pend != 0) && (cyc >= st + 2) && (cyc < endc);
                coreDone = (stale && (cyc == st || cyc == st + 1)) ||
                           (!in_win && ($urandom_range(0, 7) == 0));
                coreR    = 18'($urandom);
                if (pend != 0 && lat != 0 && cyc == st + lat) begin
                    coreDone = 1'b1;
                    coreR    = fix_en ? fix_r : rfun(cx);
                    pend     = 0;
                end else if (pend != 0 && cyc >= endc) begin
                    pend = 0;
                end
            end
        end
    end

    // Transaction model: 0 idle, 1 request in flight, 2 result presented
    logic [15:0] acc_q[$];
    int          mcount = 0, phase = 0, rise = 0;
    logic        want = 1'b0, rst_seen = 1'b1;
    logic [15:0] ix = 16'h0;
    logic [17:0] er = 18'h0;
    logic        ee = 1'b0;
    int          last_acc = 0, last_start = 0, last_rise = 0, last_hs = 0;
    int          rise_cnt = 0, start_cnt = 0;
    logic [17:0] last_r = 18'h0;
    logic [15:0] last_x = 16'h0;
    logic        last_err = 1'b0;

    initial begin : checker_proc
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                chk_eq("rst_coreStart", coreStart, 1'b0);
                chk_eq("rst_coreX", coreX, 16'h0);
                chk_eq("rst_outValid", outValid, 1'b0);
                chk_eq("rst_outR", outR, 18'h0);
                chk_eq("rst_outX", outX, 16'h0);
                chk_eq("rst_outErr", outErr, 1'b0);
                acc_q.delete();
                mcount = 0;
                phase  = 0;
            end else begin
                if (coreStart) mcount--;
                chk_eq("coreStart", coreStart, want);
                if (coreStart) begin
                    chk_eq("start_queue_nonempty", acc_q.size() != 0, 1'b1);
                    if (acc_q.size() != 0) ix = acc_q.pop_front();
                    else ix = 16'h0;
                    start_cnt++;
                    last_start = cyc;
                    phase = 1;
                    if (cm_lat != 0) begin
                        rise = cyc + cm_lat + 1; er = fix_en ? fix_r : rfun(ix); ee = 1'b0;
                    end else begin
                        rise = cyc + TIMEOUT + 2; er = 18'h0; ee = 1'b1;
                    end
                end
                if (phase == 1) chk_eq("coreX", coreX, ix);
                if (phase == 1 && cyc == rise) begin
                    phase = 2;
                    rise_cnt++;
                    last_rise = cyc; last_r = outR; last_x = outX; last_err = outErr;
                end
                chk_eq("outValid", outValid, phase == 2);
                if (phase == 2) begin
                    chk_eq("outR", outR, er);
                    chk_eq("outX", outX, ix);
                    chk_eq("outErr", outErr, ee);
                end
            end
            chk_eq("count", count, mcount);
            chk_eq("inReady", inReady, !rst && (mcount != DEPTH));
            if (phase == 2 && outReady) begin
                phase = 0;
                last_hs = cyc;
            end
            want = (phase == 0) && (mcount > 0);
            if (!rst && inValid && (mcount != DEPTH)) begin
                acc_q.push_back(inX);
                mcount++;
                last_acc = cyc;
            end
            rst_seen = rst;
        end
    end

    task automatic push(input logic [15:0] x);
        logic got;
        got = 1'b0;
        inValid = 1'b1;
        inX = x;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            got = inReady;
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        chk_eq("push_accepted", got, 1'b1);
    endtask

    task automatic wait_rise(input int bound);
        int n0, k;
        n0 = rise_cnt; k = 0;
        while (rise_cnt == n0 && k < bound) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk_eq("wait_rise_in_time", rise_cnt != n0, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (!(phase == 0 && mcount == 0) && k < bound) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk_eq("wait_idle_in_time", (phase == 0) && (mcount == 0), 1'b1);
    endtask

    initial begin : main
        int rc, sc;
        rst = 1'b1; inValid = 1'b0; inX = 16'h0; outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single request with the reference core result
        cm_mode = 1; fix_lat = 20; fix_en = 1'b1; fix_r = 18'h3F808; outReady = 1'b1;
        push(16'h1000);
        wait_rise(100);
        chk_eq("t1_accept_to_start", last_start - last_acc, 2);
        chk_eq("t1_start_to_valid", last_rise - last_start, 21);
        chk_eq("t1_outR", last_r, 18'h3F808);
        chk_eq("t1_outX", last_x, 16'h1000);
        chk_eq("t1_outErr", last_err, 1'b0);
        wait_idle(100);
        fix_en = 1'b0;

        // Burst fill behind a busy core
        fix_lat = 25;
        push(16'h7777);
        for (int i = 0; i < 4; i++) push(16'(i * 16'h1000));
        @(negedge clk);
        chk_eq("t2_count_full", count, 3'd4);
        chk_eq("t2_inReady_full", inReady, 1'b0);
        @(posedge clk);
        #1;
        push(16'h4000);
        chk_eq("t2_fifth_on_pop", last_acc, last_start);
        wait_idle(1000);

        // Downstream backpressure
        fix_lat = 5; outReady = 1'b0;
        push(16'h2222);
        wait_rise(100);
        sc = start_cnt;
        for (int i = 0; i < 4; i++) push(16'h2300 + 16'(i));
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_eq("t3_count_full", count, 3'd4);
        chk_eq("t3_no_new_start", start_cnt, sc);
        chk_eq("t3_outX_held", outX, 16'h2222);
        @(posedge clk);
        #1 outReady = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_eq("t3_hs_to_start", last_start - last_hs, 1);
        wait_idle(500);

        // Timeout
        outReady = 1'b0; cm_mode = 2;
        push(16'h3333);
        push(16'h4444);
        wait_rise(400);
        chk_eq("t4_start_to_valid", last_rise - last_start, TIMEOUT + 2);
        chk_eq("t4_outErr", last_err, 1'b1);
        chk_eq("t4_outR", last_r, 18'h0);
        chk_eq("t4_outX", last_x, 16'h3333);
        cm_mode = 1; fix_lat = 8; outReady = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_eq("t4_next_issue", last_start - last_hs, 1);
        wait_idle(200);

        // Stale done around ISSUE and the guard cycle
        cm_mode = 3;
        push(16'h5555);
        wait_rise(100);
        chk_eq("t5_start_to_valid", last_rise - last_start, 7);
        chk_eq("t5_outErr", last_err, 1'b0);
        chk_eq("t5_outR", last_r, rfun(16'h5555));
        wait_idle(100);

        // Reset while waiting with three entries queued
        cm_mode = 1; fix_lat = 30;
        for (int i = 0; i < 4; i++) push(16'h6000 + 16'(i));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("t6_queued", count, 3'd3);
        rc = rise_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk_eq("t6_no_output", rise_cnt, rc);
        chk_eq("t6_count_flushed", count, 3'd0);
        @(posedge clk);
        #1;

        // Randomized traffic
        cm_mode = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            inValid  = 1'($urandom_range(0, 1));
            inX      = 16'($urandom);
            outReady = ($urandom_range(0, 2) != 0);
            rst      = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0; rst = 1'b0; outReady = 1'b1;
        wait_idle(8000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
